// File: rtl/rx_packet_reassembler_pkg.sv
// Shared types for the RX packet reassembler: flit layout, header overlay
// and the per-VC assembly state.
package rx_packet_reassembler_pkg;

    localparam int VC_W = 1;

    typedef struct packed {
        logic [VC_W-1:0] vc;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t  metadata;
        logic [31:0] payload;
    } flit_t;

    // Header fields overlaid on payload[15:0]
    typedef struct packed {
        logic [7:0] src;
        logic [7:0] len;
    } reasm_hdr_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } reasm_state_e;

endpackage

// File: rtl/rx_packet_reassembler_fifo.sv
// socetlib_fifo: small show-ahead FIFO used as the packet completion queue.
// rdata always shows the head entry; push and pop may happen in the same cycle.
module socetlib_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Entry storage; written at the tail on push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/rx_packet_reassembler.sv
// rx_packet_reassembler: rebuilds per-VC flit streams into whole packets and
// exposes only complete packets, in completion order, on the read side.
// Optional partial-packet abort is enabled by defining RX_REASM_TIMEOUT_EN.
//
// Flit handshake: a flit is accepted in any cycle where flit_valid && flit_ready
// are both high; flit_ready does not depend on flit_valid, and the matching
// credit_granted bit is high in that same cycle.
module rx_packet_reassembler
    import rx_packet_reassembler_pkg::*;
#(
    parameter int NUM_VCS        = 2,
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_WORDS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  flit_t                          flit_in,
    input  logic                           flit_valid,
    output logic                           flit_ready,
    output logic [NUM_VCS-1:0]             credit_granted,
    output logic                           pkt_avail,
    output logic [$clog2(MAX_WORDS+1)-1:0] pkt_len,
    output logic [7:0]                     pkt_src,
    input  logic                           rd_en,
    output logic [31:0]                    rd_data,
    output logic                           err,
    output logic                           timeout_err,
    output logic [NUM_VCS-1:0]             vc_body_dbg
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int LEN_W  = $clog2(MAX_WORDS + 1);
    localparam int IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    reasm_state_e      vc_state     [NUM_VCS];
    reasm_state_e      vc_state_nxt [NUM_VCS];
    logic [SLOT_W-1:0] vc_slot      [NUM_VCS];
    logic [LEN_W-1:0]  vc_remaining [NUM_VCS];
    logic [IDX_W-1:0]  vc_word_idx  [NUM_VCS];

    logic [31:0]       slot_mem [NUM_SLOTS][MAX_WORDS];
    logic [7:0]        slot_src [NUM_SLOTS];
    logic [LEN_W-1:0]  slot_len [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] free_map;
    logic [NUM_SLOTS-1:0] free_map_nxt;

    logic [IDX_W-1:0]  rd_ptr;
    logic [SLOT_W-1:0] head_slot;
    logic              q_empty;
    logic              q_full;

    reasm_hdr_t        hdr;
    logic [VC_W-1:0]   in_vc;
    logic              in_body;
    logic              len_ok;
    logic              has_free;
    logic [SLOT_W-1:0] alloc_slot;
    logic              fire;
    logic              hdr_alloc;
    logic              hdr_bad;
    logic              body_wr;
    logic              last_word;
    logic              pop;
    logic [NUM_VCS-1:0] to_hit;

    assign hdr     = flit_in.payload[15:0];
    assign in_vc   = flit_in.metadata.vc;
    assign in_body = (vc_state[in_vc] == BODY);
    assign len_ok  = (hdr.len != 8'd0) && (hdr.len <= 8'(MAX_WORDS));

    // A header that will be stored needs a free slot; everything else is always taken
    assign flit_ready = in_body || !len_ok || has_free;
    assign fire       = flit_valid && flit_ready;
    assign hdr_alloc  = fire && !in_body && len_ok;
    assign hdr_bad    = fire && !in_body && !len_ok;
    assign body_wr    = fire && in_body;
    assign last_word  = body_wr && (vc_remaining[in_vc] == LEN_W'(1));

    assign credit_granted = fire ? (NUM_VCS'(1) << in_vc) : '0;

    assign pkt_avail = !q_empty;
    assign pkt_len   = pkt_avail ? slot_len[head_slot] : '0;
    assign pkt_src   = pkt_avail ? slot_src[head_slot] : '0;
    assign rd_data   = pkt_avail ? slot_mem[head_slot][rd_ptr] : '0;
    assign pop       = rd_en && pkt_avail && ({1'b0, rd_ptr} == (pkt_len - LEN_W'(1)));
    assign err       = hdr_bad || (rd_en && !pkt_avail);

    // Lowest-numbered free slot; uses the registered map so a slot freed this cycle waits a cycle
    always_comb begin
        alloc_slot = '0;
        has_free   = |free_map;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_map[i]) alloc_slot = SLOT_W'(i);
        end
    end

    // Per-VC next state: header opens BODY, last word or timeout closes it
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            vc_state_nxt[v] = vc_state[v];
            vc_body_dbg[v]  = (vc_state[v] == BODY);
            if (fire && (in_vc == VC_W'(v))) begin
                case (vc_state[v])
                    IDLE:    if (len_ok) vc_state_nxt[v] = BODY;
                    BODY:    if (vc_remaining[v] == LEN_W'(1)) vc_state_nxt[v] = IDLE;
                    default: vc_state_nxt[v] = IDLE;
                endcase
            end
            if (to_hit[v]) vc_state_nxt[v] = IDLE;
        end
    end

    // Free bitmap update: allocate on header, release on final read or abort
    always_comb begin
        free_map_nxt = free_map;
        if (hdr_alloc) free_map_nxt[alloc_slot] = 1'b0;
        if (pop)       free_map_nxt[head_slot]  = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (to_hit[v]) free_map_nxt[vc_slot[v]] = 1'b1;
        end
    end

    // Per-VC assembly contexts, slot metadata and the free map
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                vc_state[v]     <= IDLE;
                vc_slot[v]      <= '0;
                vc_remaining[v] <= '0;
                vc_word_idx[v]  <= '0;
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_src[s] <= '0;
                slot_len[s] <= '0;
            end
            free_map <= '1;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) vc_state[v] <= vc_state_nxt[v];
            if (hdr_alloc) begin
                vc_slot[in_vc]       <= alloc_slot;
                vc_remaining[in_vc]  <= hdr.len[LEN_W-1:0];
                vc_word_idx[in_vc]   <= '0;
                slot_src[alloc_slot] <= hdr.src;
                slot_len[alloc_slot] <= hdr.len[LEN_W-1:0];
            end
            if (body_wr) begin
                vc_remaining[in_vc] <= vc_remaining[in_vc] - LEN_W'(1);
                vc_word_idx[in_vc]  <= vc_word_idx[in_vc] + IDX_W'(1);
            end
            free_map <= free_map_nxt;
        end
    end

    // Payload storage; body words land at the VC's current word index
    always_ff @(posedge clk) begin
        if (body_wr) slot_mem[vc_slot[in_vc]][vc_word_idx[in_vc]] <= flit_in.payload;
    end

    // Read pointer walks the head packet and rewinds when it is popped
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                 rd_ptr <= '0;
        else if (pop)               rd_ptr <= '0;
        else if (rd_en && pkt_avail) rd_ptr <= rd_ptr + IDX_W'(1);
    end

`ifdef RX_REASM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt [NUM_VCS];

    // The TIMEOUT_CYCLES-th consecutive idle cycle in BODY aborts the packet
    always_comb begin
        to_hit = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            to_hit[v] = (vc_state[v] == BODY) && !(fire && (in_vc == VC_W'(v)))
                        && (idle_cnt[v] == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Idle counters: cleared by any accepted flit on the VC, count only while in BODY
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int v = 0; v < NUM_VCS; v++) idle_cnt[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if ((fire && (in_vc == VC_W'(v))) || (vc_state[v] != BODY) || to_hit[v])
                    idle_cnt[v] <= '0;
                else
                    idle_cnt[v] <= idle_cnt[v] + CNT_W'(1);
            end
        end
    end

    assign timeout_err = |to_hit;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign to_hit         = '0;
    assign timeout_err    = 1'b0;
`endif

    socetlib_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (NUM_SLOTS)
    ) u_cmpl_q (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (last_word),
        .pop   (pop),
        .wdata (vc_slot[in_vc]),
        .rdata (head_slot),
        .empty (q_empty),
        .full  (q_full)
    );

    logic unused_q_full;
    assign unused_q_full = q_full;

endmodule
